fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
Downstream drain stage for the byte FIFO. When enabled and the FIFO is non-empty, it pops one byte and serializes it on a single UART line as an 8N1 frame: start bit, 8 data bits LSB first, 1 stop bit. A programmable clocks-per-bit divider sets the baud rate. A one-byte shift register holds the frame, so the FIFO can keep filling while a byte is on the wire.

Parameters:
CLKS_PER_BIT, 16, clock cycles per UART bit; legal values are 2 and above.
DATA_WIDTH, 8, bits per frame payload; fixed at 8 for 8N1.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-high reset.
enable  input  1  permits starting a new frame; sampled only in IDLE.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  8  FIFO head byte; show-ahead, valid whenever fifo_empty=0.
fifo_pop  output  1  one-cycle pop strobe to the FIFO.
tx  output  1  serial line; idle level 1; registered.
busy  output  1  high whenever state is not IDLE.
byte_done  output  1  one-cycle pulse marking the last clock of the stop bit.

Behaviour:
- Reset (async, any time):
  - state=IDLE; tx=1, fifo_pop=0, busy=0, byte_done=0.
  - Bit counter, baud counter and shift register cleared.
  - A frame in progress is aborted. No pop is issued while rst=1.
- States: IDLE, START, DATA, STOP.
- Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1 within each bit, then wraps.
- IDLE:
  - tx=1.
  - fifo_pop is combinational: fifo_pop = (state==IDLE) & enable & ~fifo_empty.
  - On an edge where fifo_pop=1: shift register <= fifo_data; tx <= 0; state <= START; baud counter <= 0.
- START: tx=0 for exactly CLKS_PER_BIT clocks. At the counter wrap: tx <= shreg[0]; bit counter <= 0; state <= DATA.
- DATA:
  - Each bit is held CLKS_PER_BIT clocks.
  - At each wrap: shift right and increment the bit counter.
  - After bit 7's wrap: tx <= 1; state <= STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT clocks.
  - byte_done=1 during the final clock (baud counter = CLKS_PER_BIT-1); registered so it aligns with that clock.
  - At the wrap: state <= IDLE.
- Timing:
  - Frame length is 10*CLKS_PER_BIT clocks measured from the pop edge.
  - IDLE always lasts at least one clock, giving one idle tx=1 clock between back-to-back frames.
  - Pop-to-pop spacing is therefore 10*CLKS_PER_BIT+1 clocks at maximum throughput.
- Boundary conditions:
  - enable deasserted mid-frame: the current frame completes normally; no further pop.
  - fifo_empty or fifo_data changing mid-frame: ignored, since the byte is already latched.
  - fifo_empty=1 in IDLE: no pop, tx stays 1, busy=0.
  - enable and fifo_empty both toggling in IDLE: pop is decided purely on their values at that edge; never more than one pop per frame.
  - fifo_pop is never asserted outside IDLE and never for two consecutive clocks.
  - Reset mid-frame: tx returns to 1 asynchronously. The popped byte is lost; this is accepted.
- busy = (state != IDLE), decoded from registered state.

Test Plan:
- CLKS_PER_BIT=4, FIFO holds 0xA5, enable=1 → fifo_pop high exactly 1 clock.
  - tx sequence, 4 clocks each: 0 | 1,0,1,0,0,1,0,1 | 1.
  - byte_done pulses once at clock 40 after the pop edge; busy high 40 clocks.
- FIFO holds 0x01,0x80,0xFF, enable=1 → three pops spaced 41 clocks apart.
  - Data bits decode to 0x01, 0x80, 0xFF.
  - Exactly one tx=1 idle clock between stop and next start.
- fifo_empty=1, enable=1 for 100 clocks → fifo_pop=0, tx=1, busy=0, byte_done=0 throughout.
- enable=1, pop 0x3C, drop enable at clock 10 with FIFO still non-empty → 0x3C frame completes; no further pop while enable=0; raise enable → next pop on the following clock.
- rst asserted at clock 17 of a 0x55 frame → tx=1, busy=0, fifo_pop=0 immediately.
  - After release with FIFO non-empty, the next pop occurs one clock later and a full frame follows.
- CLKS_PER_BIT=2, byte 0x00 → tx low for 18 clocks (start + 8 data), then high 2 clocks; byte_done at clock 20.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a show-ahead byte FIFO onto an 8N1 UART line.
// One byte is latched per frame, so the FIFO may refill while the
// frame is on the wire. Baud rate is set by CLKS_PER_BIT.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    output logic                  tx,
    output logic                  busy,
    output logic                  byte_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         baud_q, baud_d;
    logic [CW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  tx_q, tx_d;
    logic                  done_q, done_d;
    logic                  wrap;

    assign wrap = (baud_q == BAUD_LAST);

    // Pop only from IDLE; reset gates it so nothing is consumed while held.
    assign fifo_pop  = (state_q == IDLE) & enable & ~fifo_empty & ~rst;
    assign busy      = (state_q != IDLE);
    assign tx        = tx_q;
    assign byte_done = done_q;

    // Next-state: frame sequencing, baud/bit counting, line level.
    always_comb begin
        state_d = state_q;
        baud_d  = wrap ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (fifo_pop) begin
                    shreg_d = fifo_data;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (wrap) begin
                    tx_d    = shreg_q[0];
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (wrap) begin
                    shreg_d = shreg_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == BIT_LAST) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Next bit on the wire is the one about to become LSB.
                        tx_d = shreg_q[1];
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (wrap) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Registered so the pulse lines up with the final stop-bit clock.
        done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
    end

    // State and datapath registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: table-driven frame checks on a CLKS_PER_BIT=4 instance,
// a UART receiver model scoring decoded bytes against a queue of popped
// bytes, and hand-written corner sequences (idle, enable drop, reset
// mid-frame, CLKS_PER_BIT=2).
module tb_fifo_uart_tx;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       en, empty, pop, tx, busy, done;
    logic [7:0] data;
    logic       en2, empty2, pop2, tx2, busy2, done2;
    logic [7:0] data2;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) u_dut4 (
        .clk(clk), .rst(rst), .enable(en), .fifo_empty(empty), .fifo_data(data),
        .fifo_pop(pop), .tx(tx), .busy(busy), .byte_done(done)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(2), .DATA_WIDTH(8)) u_dut2 (
        .clk(clk), .rst(rst), .enable(en2), .fifo_empty(empty2), .fifo_data(data2),
        .fifo_pop(pop2), .tx(tx2), .busy(busy2), .byte_done(done2)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit popped, popped2;
    logic [7:0] fq[$];     // bench FIFO contents feeding u_dut4
    logic [7:0] exp_q[$];  // bytes popped, awaiting the receiver

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;  // tx level per bit slot, slot 0 = start bit
        int         nload;  // table entries pushed into the FIFO at this point
    } vec_t;
    vec_t vec[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_fifo();
        empty = (fq.size() == 0);
        data  = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    // One clock: sample pop strobes before the edge, retire popped bytes after it.
    task automatic step();
        bit p, p2;
        #1;
        p  = pop;
        p2 = pop2;
        @(posedge clk);
        #1;
        cyc++;
        popped  = p;
        popped2 = p2;
        if (p && fq.size() != 0) begin
            exp_q.push_back(fq[0]);
            void'(fq.pop_front());
        end
        if (p2) empty2 = 1'b1;
        drive_fifo();
        #1;
    endtask

    // Expect a pop within maxwait clocks, then check every clock of the frame
    // and the single idle clock after it.
    task automatic check_frame(input logic [9:0] f, input int maxwait);
        int n = 0;
        do begin
            step();
            n++;
        end while (!popped && n < maxwait);
        chk("pop_seen", popped, 1);
        if (!popped) return;
        for (int c = 1; c <= 10 * CPB; c++) begin
            if (c > 1) step();
            chk("frame_tx", tx, f[(c - 1) / CPB]);
            chk("frame_busy", busy, 1);
            chk("frame_byte_done", done, (c == 10 * CPB) ? 1 : 0);
            chk("frame_no_pop", pop, 0);
        end
        step();
        chk("idle_tx", tx, 1);
        chk("idle_busy", busy, 0);
        chk("idle_byte_done", done, 0);
    endtask

    // UART receiver model: samples mid-bit on falling clock edges.
    initial begin
        bit         ract = 0;
        int         rcnt = 0;
        logic [7:0] rbyte = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                ract = 0;
            end else if (!ract) begin
                if (tx === 1'b0) begin
                    ract = 1;
                    rcnt = 0;
                end
            end else begin
                int k, j;
                rcnt++;
                k = rcnt - CPB / 2;
                if (k >= 0 && k % CPB == 0) begin
                    j = k / CPB;
                    if (j == 0) chk("rx_start", tx, 0);
                    else if (j <= 8) rbyte[j-1] = tx;
                    else begin
                        chk("rx_stop", tx, 1);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL rx_unexpected: got %0h expected no frame", rbyte);
                        end else begin
                            chk("rx_byte", rbyte, exp_q.pop_front());
                        end
                        ract = 0;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec[0] = '{8'hA5, 10'b1101001010, 1};
        vec[1] = '{8'h01, 10'b1000000010, 3};
        vec[2] = '{8'h80, 10'b1100000000, 0};
        vec[3] = '{8'hFF, 10'b1111111110, 0};

        en = 1'b1; drive_fifo();
        en2 = 1'b1; empty2 = 1'b0; data2 = 8'h00;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_byte_done", done, 0);
        chk("rst_pop", pop, 0);
        chk("rst_pop_gated", pop2, 0);
        chk("rst_tx2", tx2, 1);
        empty2 = 1'b1;
        rst = 1'b0;
        #1;

        // Table: single frame, then three back-to-back frames.
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < vec[i].nload; k++) fq.push_back(vec[i + k].data);
            drive_fifo();
            check_frame(vec[i].frame, 1);
        end

        // Empty FIFO with enable high: line stays idle.
        for (int c = 0; c < 100; c++) begin
            step();
            chk("empty_pop", pop, 0);
            chk("empty_tx", tx, 1);
            chk("empty_busy", busy, 0);
            chk("empty_byte_done", done, 0);
        end

        // Enable dropped mid-frame; head byte changes under the frame.
        fq.push_back(8'h3C);
        fq.push_back(8'h99);
        drive_fifo();
        step();
        chk("en_pop_3c", popped, 1);
        for (int c = 2; c <= 10 * CPB; c++) begin
            step();
            if (c == 10) en = 1'b0;
            chk("en_busy", busy, 1);
            chk("en_no_pop", pop, 0);
        end
        for (int c = 0; c < 20; c++) begin
            step();
            chk("en_off_pop", pop, 0);
            chk("en_off_busy", busy, 0);
            chk("en_off_tx", tx, 1);
        end
        en = 1'b1;
        #1;
        chk("en_on_pop", pop, 1);
        step();
        chk("en_pop_99", popped, 1);
        repeat (10 * CPB) step();
        chk("en_idle_busy", busy, 0);

        // Reset at clock 17 of a 0x55 frame.
        fq.push_back(8'h55);
        fq.push_back(8'hC3);
        drive_fifo();
        step();
        chk("rst_pop_55", popped, 1);
        for (int c = 2; c <= 17; c++) step();
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("midrst_tx", tx, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_pop", pop, 0);
        exp_q.delete();
        step();
        step();
        chk("midrst_no_pop", popped, 0);
        rst = 1'b0;
        check_frame(10'b1110000110, 1);

        // CLKS_PER_BIT=2 with 0x00: 18 low clocks then 2 high.
        data2 = 8'h00;
        empty2 = 1'b0;
        step();
        chk("cpb2_pop", popped2, 1);
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) step();
            chk("cpb2_tx", tx2, (c <= 18) ? 0 : 1);
            chk("cpb2_byte_done", done2, (c == 20) ? 1 : 0);
            chk("cpb2_busy", busy2, 1);
        end
        step();
        chk("cpb2_idle_busy", busy2, 0);
        chk("cpb2_idle_tx", tx2, 1);
        chk("cpb2_no_pop", pop2, 0);

        repeat (4) step();
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("fifo_drained", fq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
